// File: rtl/stream_manip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_manip_pkg
// Description : Shared types and helpers for the GTX stream manipulator.
//               - Scheduler state encoding (IDLE/DELAY/ACTIVE/GAP/FINISH)
//               - Default counter and data widths
//               - Rotate-left-by-1 helper used for walking XOR masks
// Revision    : 1.0  initial release
// ============================================================================
package stream_manip_pkg;

    localparam int C_CNT_WIDTH  = 16;
    localparam int C_DATA_WIDTH = 80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DELAY  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_t;

    // Rotate left by one; the MSB wraps into bit 0.
    function automatic logic [C_DATA_WIDTH-1:0] rotl1(input logic [C_DATA_WIDTH-1:0] i_v);
        return {i_v[C_DATA_WIDTH-2:0], i_v[C_DATA_WIDTH-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : cycle_down_counter
// Description : Loadable down counter with zero detect. The scheduler loads
//               (phase length - 1) on phase entry, so o_zero marks the last
//               cycle of the phase.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_load         - load i_load_val (has priority over i_dec)
//               i_load_val     - value to load
//               i_dec          - decrement by one (stops at zero)
//               o_zero         - current count is zero
// Revision    : 1.0  initial release
// ============================================================================
module cycle_down_counter
    import stream_manip_pkg::*;
#(
    parameter int WIDTH = C_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count_q;
    logic [WIDTH-1:0] w_count_d;

    assign o_zero = (r_count_q == '0);

    always_comb begin
        w_count_d = r_count_q;
        if (i_load) begin
            w_count_d = i_load_val;
        end else if (i_dec && !o_zero) begin
            w_count_d = r_count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_inject_sched.sv
`default_nettype none
// ============================================================================
// Module      : stream_inject_sched
// Description : Error-injection campaign scheduler for the 80-bit GTX user
//               data stream. After START it waits CFG_DELAY cycles, then
//               emits bursts of INJ_EN/INJ_MASK separated by idle gaps, with
//               an optional walking (rotating) mask.
// Ports       : USER_CLK, RESET      - clock, synchronous active-high reset
//               START, ABORT         - campaign control (ABORT wins)
//               CFG_*                - campaign configuration, latched at START
//               INJ_EN, INJ_MASK     - per-cycle manipulator enable and XOR mask
//               BUSY, DONE           - campaign status / completion pulse
//               BURST_COUNT          - completed bursts (saturating)
// Revision    : 1.0  initial release
// ============================================================================
module stream_inject_sched
    import stream_manip_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int CNT_WIDTH  = C_CNT_WIDTH
) (
    input  logic                  USER_CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [CNT_WIDTH-1:0]  CFG_DELAY,
    input  logic [CNT_WIDTH-1:0]  CFG_BURST_LEN,
    input  logic [CNT_WIDTH-1:0]  CFG_GAP_LEN,
    input  logic [CNT_WIDTH-1:0]  CFG_NUM_BURSTS,
    input  logic [DATA_WIDTH-1:0] CFG_MASK_SEED,
    input  logic                  CFG_ROTATE,
    output logic                  INJ_EN,
    output logic [DATA_WIDTH-1:0] INJ_MASK,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [CNT_WIDTH-1:0]  BURST_COUNT
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // State, latched configuration, mask and counters
    // ------------------------------------------------------------------
    sched_state_t          r_state_q,       w_state_d;
    logic [DATA_WIDTH-1:0] r_mask_q,        w_mask_d;
    logic [CNT_WIDTH-1:0]  r_burst_len_q,   w_burst_len_d;   // always >= 1
    logic [CNT_WIDTH-1:0]  r_gap_len_q,     w_gap_len_d;
    logic [CNT_WIDTH-1:0]  r_num_bursts_q,  w_num_bursts_d;
    logic                  r_rotate_q,      w_rotate_d;
    logic [CNT_WIDTH-1:0]  r_burst_count_q, w_burst_count_d;

    // Registered outputs
    logic                  r_inj_en_q,      w_inj_en_d;
    logic [DATA_WIDTH-1:0] r_inj_mask_q,    w_inj_mask_d;
    logic                  r_busy_q,        w_busy_d;
    logic                  r_done_q,        w_done_d;

    // Phase counter control
    logic                  w_cnt_load;
    logic [CNT_WIDTH-1:0]  w_cnt_load_val;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;

    logic [DATA_WIDTH-1:0] w_mask_rot;
    logic [CNT_WIDTH-1:0]  w_cfg_burst_norm;
    logic [CNT_WIDTH:0]    w_count_plus1;
    logic                  w_last_burst;
    logic [CNT_WIDTH-1:0]  w_count_inc;

    cycle_down_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_phase_cnt (
        .clk        (USER_CLK),
        .rst        (RESET),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // The shared helper is fixed at the package data width; other widths
    // fall back to an equivalent local rotate.
    if (DATA_WIDTH == C_DATA_WIDTH) begin : g_rot_pkg
        assign w_mask_rot = rotl1(r_mask_q);
    end else begin : g_rot_generic
        assign w_mask_rot = {r_mask_q[DATA_WIDTH-2:0], r_mask_q[DATA_WIDTH-1]};
    end

    assign w_cfg_burst_norm = (CFG_BURST_LEN == '0) ? c_one : CFG_BURST_LEN;

    // One extra bit so the +1 compare cannot wrap.
    assign w_count_plus1 = {1'b0, r_burst_count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};
    assign w_last_burst  = (r_num_bursts_q != '0) &&
                           (w_count_plus1 == {1'b0, r_num_bursts_q});
    assign w_count_inc   = (r_burst_count_q == '1) ? r_burst_count_q
                                                   : r_burst_count_q + c_one;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d       = r_state_q;
        w_mask_d        = r_mask_q;
        w_burst_len_d   = r_burst_len_q;
        w_gap_len_d     = r_gap_len_q;
        w_num_bursts_d  = r_num_bursts_q;
        w_rotate_d      = r_rotate_q;
        w_burst_count_d = r_burst_count_q;
        w_cnt_load      = 1'b0;
        w_cnt_load_val  = '0;
        w_cnt_dec       = 1'b0;

        if (ABORT) begin
            w_state_d = ST_IDLE;
        end else begin
            unique case (r_state_q)
                ST_IDLE: begin
                    if (START) begin
                        // CFG_DELAY and the seed are consumed immediately, so
                        // only the values needed later are held.
                        w_burst_len_d   = w_cfg_burst_norm;
                        w_gap_len_d     = CFG_GAP_LEN;
                        w_num_bursts_d  = CFG_NUM_BURSTS;
                        w_rotate_d      = CFG_ROTATE;
                        w_burst_count_d = '0;
                        w_mask_d        = CFG_MASK_SEED;
                        w_cnt_load      = 1'b1;
                        if (CFG_DELAY != '0) begin
                            w_state_d      = ST_DELAY;
                            w_cnt_load_val = CFG_DELAY - c_one;
                        end else begin
                            w_state_d      = ST_ACTIVE;
                            w_cnt_load_val = w_cfg_burst_norm - c_one;
                        end
                    end
                end

                ST_DELAY: begin
                    if (w_cnt_zero) begin
                        w_state_d      = ST_ACTIVE;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = r_burst_len_q - c_one;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end

                ST_ACTIVE: begin
                    if (w_cnt_zero) begin
                        // Last cycle of the burst
                        w_burst_count_d = w_count_inc;
                        if (r_rotate_q) begin
                            w_mask_d = w_mask_rot;
                        end
                        if (w_last_burst) begin
                            w_state_d = ST_FINISH;
                        end else if (r_gap_len_q != '0) begin
                            w_state_d      = ST_GAP;
                            w_cnt_load     = 1'b1;
                            w_cnt_load_val = r_gap_len_q - c_one;
                        end else begin
                            // Back-to-back: stay ACTIVE and rearm the burst
                            w_cnt_load     = 1'b1;
                            w_cnt_load_val = r_burst_len_q - c_one;
                        end
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end

                ST_GAP: begin
                    if (w_cnt_zero) begin
                        w_state_d      = ST_ACTIVE;
                        w_cnt_load     = 1'b1;
                        w_cnt_load_val = r_burst_len_q - c_one;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end

                ST_FINISH: begin
                    w_state_d = ST_IDLE;
                end

                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: outputs follow the state one cycle later, except that
    // ABORT clears them on the same edge it is sampled.
    // ------------------------------------------------------------------
    always_comb begin
        w_inj_en_d   = !ABORT && (r_state_q == ST_ACTIVE);
        w_inj_mask_d = w_inj_en_d ? r_mask_q : '0;
        w_busy_d     = !ABORT && ((r_state_q == ST_DELAY) ||
                                  (r_state_q == ST_ACTIVE) ||
                                  (r_state_q == ST_GAP));
        w_done_d     = !ABORT && (r_state_q == ST_FINISH);
    end

    always_ff @(posedge USER_CLK) begin
        if (RESET) begin
            r_state_q       <= ST_IDLE;
            r_mask_q        <= '0;
            r_burst_len_q   <= '0;
            r_gap_len_q     <= '0;
            r_num_bursts_q  <= '0;
            r_rotate_q      <= 1'b0;
            r_burst_count_q <= '0;
            r_inj_en_q      <= 1'b0;
            r_inj_mask_q    <= '0;
            r_busy_q        <= 1'b0;
            r_done_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_mask_q        <= w_mask_d;
            r_burst_len_q   <= w_burst_len_d;
            r_gap_len_q     <= w_gap_len_d;
            r_num_bursts_q  <= w_num_bursts_d;
            r_rotate_q      <= w_rotate_d;
            r_burst_count_q <= w_burst_count_d;
            r_inj_en_q      <= w_inj_en_d;
            r_inj_mask_q    <= w_inj_mask_d;
            r_busy_q        <= w_busy_d;
            r_done_q        <= w_done_d;
        end
    end

    assign INJ_EN      = r_inj_en_q;
    assign INJ_MASK    = r_inj_mask_q;
    assign BUSY        = r_busy_q;
    assign DONE        = r_done_q;
    assign BURST_COUNT = r_burst_count_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_inject_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_inject_sched
// Description : Scoreboard bench for stream_inject_sched. On each accepted
//               START the reference model expands the whole campaign into a
//               per-cycle timeline of expected outputs; the driver pushes one
//               expected entry per clock and an independent monitor compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stream_inject_sched;

    localparam int DW      = 80;
    localparam int CW      = 16;
    localparam int HORIZON = 400;

    logic          user_clk;
    logic          RESET, START, ABORT, CFG_ROTATE;
    logic [CW-1:0] CFG_DELAY, CFG_BURST_LEN, CFG_GAP_LEN, CFG_NUM_BURSTS;
    logic [DW-1:0] CFG_MASK_SEED;
    logic          INJ_EN, BUSY, DONE;
    logic [DW-1:0] INJ_MASK;
    logic [CW-1:0] BURST_COUNT;

    stream_inject_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .USER_CLK       (user_clk),
        .RESET          (RESET),
        .START          (START),
        .ABORT          (ABORT),
        .CFG_DELAY      (CFG_DELAY),
        .CFG_BURST_LEN  (CFG_BURST_LEN),
        .CFG_GAP_LEN    (CFG_GAP_LEN),
        .CFG_NUM_BURSTS (CFG_NUM_BURSTS),
        .CFG_MASK_SEED  (CFG_MASK_SEED),
        .CFG_ROTATE     (CFG_ROTATE),
        .INJ_EN         (INJ_EN),
        .INJ_MASK       (INJ_MASK),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .BURST_COUNT    (BURST_COUNT)
    );

    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    typedef struct {
        logic          inj;
        logic [DW-1:0] mask;
        logic          busy;
        logic          done;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];   // scoreboard: one entry per clock edge
    exp_t          plan[$];    // remaining timeline of the running campaign
    logic [CW-1:0] last_cnt;
    bit            inf_mode;
    bit            running;
    int            checks;
    int            failures;

    // staged configuration, applied to the DUT at the next negedge
    logic [CW-1:0] s_delay, s_burst, s_gap, s_num;
    logic [DW-1:0] s_seed;
    logic          s_rot;

    function automatic logic [DW-1:0] ref_rotl(input logic [DW-1:0] v);
        return (v << 1) | (v >> (DW - 1));
    endfunction

    // Expand a campaign into its per-cycle expected outputs.
    task automatic build_plan(input int dly, input int blen, input int gap, input int num,
                              input logic [DW-1:0] seed, input logic rot);
        exp_t          e;
        logic [DW-1:0] m;
        logic [CW-1:0] cnt;
        int            bl;
        bl  = (blen == 0) ? 1 : blen;
        m   = seed;
        cnt = '0;
        for (int i = 0; i < dly; i++) begin
            e = '{inj: 1'b0, mask: '0, busy: 1'b1, done: 1'b0, cnt: cnt};
            plan.push_back(e);
        end
        for (int b = 0; plan.size() < HORIZON; b++) begin
            for (int k = 0; k < bl; k++) begin
                if (k == bl - 1 && cnt != '1) cnt = cnt + 1'b1;
                e = '{inj: 1'b1, mask: m, busy: 1'b1, done: 1'b0, cnt: cnt};
                plan.push_back(e);
            end
            if (rot) m = ref_rotl(m);
            if (num != 0 && b + 1 == num) begin
                e = '{inj: 1'b0, mask: '0, busy: 1'b0, done: 1'b1, cnt: cnt};
                plan.push_back(e);
                break;
            end
            for (int g = 0; g < gap; g++) begin
                e = '{inj: 1'b0, mask: '0, busy: 1'b1, done: 1'b0, cnt: cnt};
                plan.push_back(e);
            end
        end
    endtask

    // Expected outputs after the coming edge, from the inputs just applied.
    task automatic model_edge();
        exp_t e;
        e = '{inj: 1'b0, mask: '0, busy: 1'b0, done: 1'b0, cnt: last_cnt};
        if (RESET) begin
            plan.delete();
            inf_mode = 1'b0;
            e.cnt    = '0;
        end else if (ABORT) begin
            plan.delete();
            inf_mode = 1'b0;
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
        end else if (START) begin
            build_plan(int'(CFG_DELAY), int'(CFG_BURST_LEN), int'(CFG_GAP_LEN),
                       int'(CFG_NUM_BURSTS), CFG_MASK_SEED, CFG_ROTATE);
            inf_mode = (CFG_NUM_BURSTS == '0);
            e.cnt    = '0;
        end
        last_cnt = e.cnt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic ab, input logic rs);
        @(negedge user_clk);
        START          = st;
        ABORT          = ab;
        RESET          = rs;
        CFG_DELAY      = s_delay;
        CFG_BURST_LEN  = s_burst;
        CFG_GAP_LEN    = s_gap;
        CFG_NUM_BURSTS = s_num;
        CFG_MASK_SEED  = s_seed;
        CFG_ROTATE     = s_rot;
        model_edge();
        running = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_cfg(input int d, input int b, input int g, input int n,
                           input logic [DW-1:0] seed, input logic rot);
        s_delay = CW'(d);
        s_burst = CW'(b);
        s_gap   = CW'(g);
        s_num   = CW'(n);
        s_seed  = seed;
        s_rot   = rot;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, got, want);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(posedge user_clk) begin
        exp_t e;
        #1;
        if (running) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow t=%0t got=empty want=entry", $time);
            end else begin
                e = exp_q.pop_front();
                chk("inj_en",      DW'(INJ_EN),      DW'(e.inj));
                chk("inj_mask",    INJ_MASK,         e.mask);
                chk("busy",        DW'(BUSY),        DW'(e.busy));
                chk("done",        DW'(DONE),        DW'(e.done));
                chk("burst_count", DW'(BURST_COUNT), DW'(e.cnt));
            end
        end
    end

    initial begin
        logic [95:0]   r96;
        logic [DW-1:0] one, bit79;
        bit            st, ab, rs;
        checks   = 0;
        failures = 0;
        running  = 1'b0;
        inf_mode = 1'b0;
        last_cnt = '0;
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; CFG_ROTATE = 1'b0;
        CFG_DELAY = '0; CFG_BURST_LEN = '0; CFG_GAP_LEN = '0; CFG_NUM_BURSTS = '0;
        CFG_MASK_SEED = '0;
        one   = DW'(1);
        bit79 = one << (DW - 1);
        set_cfg(0, 0, 0, 0, '0, 1'b0);

        // reset state
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        idle(2);

        // delay/burst/gap timing, two bursts, fixed mask
        set_cfg(3, 2, 4, 2, one, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(20);

        // back-to-back bursts with walking mask across the MSB wrap
        set_cfg(0, 1, 0, 3, bit79, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        idle(8);

        // infinite mode aborted after five bursts
        set_cfg(0, 1, 1, 0, 80'h5A, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(10);
        drive(1'b0, 1'b1, 1'b0);
        idle(4);

        // second START during a gap with a new seed is ignored
        set_cfg(1, 2, 5, 2, 80'hA5, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        idle(5);
        set_cfg(0, 1, 0, 1, 80'hFFFF, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(14);

        // START and ABORT together while idle
        drive(1'b1, 1'b1, 1'b0);
        idle(3);

        // RESET during ACTIVE, then a clean campaign
        set_cfg(0, 3, 2, 3, 80'h3C, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b0);
        idle(18);

        // all-zero seed, and BURST_LEN=0 treated as one
        set_cfg(1, 2, 1, 2, '0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        idle(10);
        set_cfg(2, 0, 0, 2, 80'h81, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        idle(8);

        // randomized campaigns; configuration churns every cycle
        for (int c = 0; c < 3000; c++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            set_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 7) == 0) ? '0 : r96[DW-1:0],
                    1'($urandom_range(0, 1)));
            st = ($urandom_range(0, 7) == 0);
            ab = ($urandom_range(0, 63) == 0) || (inf_mode && plan.size() < 4);
            rs = ($urandom_range(0, 499) == 0);
            drive(st, ab, rs);
        end
        idle(4);

        @(posedge user_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
